// File: rtl/xsr_pkg.sv
// Shared types and constants for the xsr receive controller.
package xsr_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] DW_5 = 2'b00;
  localparam logic [1:0] DW_6 = 2'b01;
  localparam logic [1:0] DW_7 = 2'b10;
  localparam logic [1:0] DW_8 = 2'b11;

  typedef enum logic [1:0] {ST_ARMED, ST_BUSY, ST_EVAL} state_t;

  typedef struct packed {
    logic [1:0] dw;
    logic [1:0] par;
    logic       stop;
  } cfg_t;

  localparam cfg_t CFG_RST = '{dw: DW_8, par: PAR_ODD, stop: 1'b0};

  function automatic logic par_en(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  // start + data + optional parity + stop bit(s)
  function automatic logic [5:0] frame_bits(input cfg_t c);
    return 6'd6 + {4'b0, c.dw} + {5'b0, par_en(c.par)} + (c.stop ? 6'd2 : 6'd1);
  endfunction

endpackage

// File: rtl/xsr_frame_dec.sv
// Combinational decode of a captured, right-justified frame (start bit at bit 0).
module xsr_frame_dec
  import xsr_pkg::*;
(
  input  logic [11:0] frame_i,
  input  cfg_t        cfg_i,
  output logic [7:0]  dat_o,
  output logic        perr_o,
  output logic        ferr_o,
  output logic        brk_o
);

  logic       pe;
  logic       ones;
  logic [3:0] p_idx, s1_idx, s2_idx;

  always_comb begin
    pe     = par_en(cfg_i.par);
    p_idx  = 4'd6 + {2'b0, cfg_i.dw};
    s1_idx = p_idx + {3'b0, pe};
    s2_idx = s1_idx + 4'd1;
    dat_o  = frame_i[8:1] & (8'hFF >> (2'd3 - cfg_i.dw));
    ones   = ^dat_o ^ (pe & frame_i[p_idx]);
    perr_o = pe & ((cfg_i.par == PAR_EVEN) ? ones : ~ones);
    ferr_o = frame_i[0] | ~frame_i[s1_idx] | (cfg_i.stop & ~frame_i[s2_idx]);
    // bits above the frame length are zero-filled at capture
    brk_o  = ~|frame_i;
  end

endmodule

// File: rtl/xsr_rxctl.sv
// xsr receive controller: line config, frame tracking, decode and one-entry holding register.
module xsr_rxctl
  import xsr_pkg::*;
#(
  parameter int               SRW      = 64,
  parameter int               BAUDW    = 64,
  parameter logic [BAUDW-1:0] BAUD_RST = BAUDW'(49)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_dw_i,
  input  logic [1:0]       cfg_par_i,
  input  logic             cfg_stop_i,
  input  logic [BAUDW-1:0] cfg_baud_i,
  input  logic             rx_en_i,
  output logic [5:0]       bits_o,
  output logic [BAUDW-1:0] baud_o,
  input  logic             idle_i,
  input  logic [SRW-1:0]   sr_i,
  output logic [7:0]       rx_dat_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             perr_o,
  output logic             ferr_o,
  output logic             brk_o,
  output logic             ovr_o,
  input  logic             ovr_clr_i
);

  state_t           state_q;
  cfg_t             cfg_q, pcfg_q, cfg_wr;
  logic [BAUDW-1:0] baud_q, pbaud_q;
  logic             pend_q;
  logic [11:0]      frame_q, cap_d;
  logic [7:0]       dat_q, dec_dat;
  logic             perr_q, ferr_q, brk_q, vld_q, ovr_q;
  logic             dec_perr, dec_ferr, dec_brk;
  logic             cfg_ok;
  logic [5:0]       bits;

  assign cfg_wr = '{dw: cfg_dw_i, par: cfg_par_i, stop: cfg_stop_i};
  assign cfg_ok = (state_q == ST_ARMED) && idle_i;
  assign bits   = frame_bits(cfg_q);
  // frame sits at the top of sr_i; shift it down so the start bit lands at bit 0
  assign cap_d  = 12'(sr_i >> (SRW - int'(bits)));

  xsr_frame_dec u_dec (
    .frame_i(frame_q),
    .cfg_i  (cfg_q),
    .dat_o  (dec_dat),
    .perr_o (dec_perr),
    .ferr_o (dec_ferr),
    .brk_o  (dec_brk)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_ARMED;
      cfg_q   <= CFG_RST;
      pcfg_q  <= CFG_RST;
      baud_q  <= BAUD_RST;
      pbaud_q <= BAUD_RST;
      pend_q  <= 1'b0;
      frame_q <= '0;
      dat_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        if (cfg_ok) begin
          cfg_q  <= cfg_wr;
          baud_q <= cfg_baud_i;
          pend_q <= 1'b0;
        end else begin
          pcfg_q  <= cfg_wr;
          pbaud_q <= cfg_baud_i;
          pend_q  <= 1'b1;
        end
      end else if (pend_q && cfg_ok) begin
        cfg_q  <= pcfg_q;
        baud_q <= pbaud_q;
        pend_q <= 1'b0;
      end

      if (vld_q && rx_ready_i) vld_q <= 1'b0;
      if (ovr_clr_i) ovr_q <= 1'b0;

      // later assignments below win: a load beats the accept-clear, a set beats ovr_clr
      case (state_q)
        ST_ARMED: if (!idle_i) state_q <= ST_BUSY;
        ST_BUSY: if (idle_i) begin
          frame_q <= cap_d;
          state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          state_q <= ST_ARMED;
          if (rx_en_i) begin
            if (vld_q && !rx_ready_i) ovr_q <= 1'b1;
            else begin
              dat_q  <= dec_dat;
              perr_q <= dec_perr;
              ferr_q <= dec_ferr;
              brk_q  <= dec_brk;
              vld_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  assign bits_o     = bits;
  assign baud_o     = baud_q;
  assign rx_dat_o   = dat_q;
  assign rx_valid_o = vld_q;
  assign perr_o     = perr_q;
  assign ferr_o     = ferr_q;
  assign brk_o      = brk_q;
  assign ovr_o      = ovr_q;

endmodule

// File: tb/tb_xsr_rxctl.sv
// Bench for xsr_rxctl: spec-level model checked every cycle plus literal spot checks.
module tb_xsr_rxctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_dw = 2'b0, cfg_par = 2'b0;
  logic        cfg_stop = 1'b0;
  logic [63:0] cfg_baud = '0;
  logic        rx_en = 1'b1;
  logic [5:0]  bits;
  logic [63:0] baud;
  logic        idle = 1'b1;
  logic [63:0] sr = '0;
  logic [7:0]  rx_dat;
  logic        rx_valid, rx_ready = 1'b0;
  logic        perr, ferr, brk, ovr, ovr_clr = 1'b0;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  xsr_rxctl dut (
    .clk_i(clk), .reset_ni(rst_n), .cfg_we_i(cfg_we), .cfg_dw_i(cfg_dw),
    .cfg_par_i(cfg_par), .cfg_stop_i(cfg_stop), .cfg_baud_i(cfg_baud),
    .rx_en_i(rx_en), .bits_o(bits), .baud_o(baud), .idle_i(idle), .sr_i(sr),
    .rx_dat_o(rx_dat), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .perr_o(perr), .ferr_o(ferr), .brk_o(brk), .ovr_o(ovr), .ovr_clr_i(ovr_clr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_dw, m_par, m_stop, p_dw, p_par, p_stop;
  logic [63:0] m_baud, p_baud, m_field;
  bit m_in, m_ev, m_pend;
  int m_vld, m_dat, m_perr, m_ferr, m_brk, m_ovr;

  function automatic int nbits(input int dw, input int par, input int st);
    return 1 + (5 + dw) + ((par == 1 || par == 2) ? 1 : 0) + (st ? 2 : 1);
  endfunction

  task automatic decode(input logic [63:0] f, input int dw, input int par, input int st,
                        output int dat, output int pe_r, output int fe_r, output int bk_r);
    int d, pe, ones;
    d    = 5 + dw;
    pe   = (par == 1 || par == 2) ? 1 : 0;
    dat  = int'((f >> 1) & ((64'd1 << d) - 1));
    ones = $countones(dat) + (pe != 0 ? int'((f >> (1 + d)) & 1) : 0);
    pe_r = (pe == 0) ? 0 : ((par == 1) ? ones % 2 : 1 - ones % 2);
    fe_r = (f[0] || ((f >> (1 + d + pe)) & 1) == 0 ||
            (st == 1 && ((f >> (2 + d + pe)) & 1) == 0)) ? 1 : 0;
    bk_r = (f == 0) ? 1 : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dw = 3; m_par = 2; m_stop = 0; m_baud = 64'd49;
      p_dw = 3; p_par = 2; p_stop = 0; p_baud = 64'd49; m_pend = 0;
      m_in = 0; m_ev = 0; m_field = '0;
      m_vld = 0; m_dat = 0; m_perr = 0; m_ferr = 0; m_brk = 0; m_ovr = 0;
    end else begin
      bit ok;
      int d, pr, fr, bk;
      ok = !m_in && !m_ev && idle;
      if (cfg_we) begin
        if (ok) begin m_dw = cfg_dw; m_par = cfg_par; m_stop = cfg_stop; m_baud = cfg_baud; m_pend = 0; end
        else begin p_dw = cfg_dw; p_par = cfg_par; p_stop = cfg_stop; p_baud = cfg_baud; m_pend = 1; end
      end else if (m_pend && ok) begin
        m_dw = p_dw; m_par = p_par; m_stop = p_stop; m_baud = p_baud; m_pend = 0;
      end
      if (m_vld != 0 && rx_ready) m_vld = 0;
      if (ovr_clr) m_ovr = 0;
      if (m_ev) begin
        m_ev = 0;
        if (rx_en) begin
          if (m_vld != 0) m_ovr = 1;
          else begin
            decode(m_field, m_dw, m_par, m_stop, d, pr, fr, bk);
            m_dat = d; m_perr = pr; m_ferr = fr; m_brk = bk; m_vld = 1;
          end
        end
      end else if (m_in && idle) begin
        m_field = sr >> (64 - nbits(m_dw, m_par, m_stop));
        m_in = 0; m_ev = 1;
      end else if (!m_in && !idle) m_in = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", rx_valid, m_vld);
      chk("dat", rx_dat, m_dat);
      chk("perr", perr, m_perr);
      chk("ferr", ferr, m_ferr);
      chk("brk", brk, m_brk);
      chk("ovr", ovr, m_ovr);
      chk("bits", bits, nbits(m_dw, m_par, m_stop));
      chk("baud", baud, m_baud);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain; 1: rx_ready during EVAL cycle; 2: ovr_clr during EVAL cycle
  task automatic send_frame(input logic [11:0] f, input int n, input int mode);
    sr = 64'(f) << (64 - n);
    idle = 1'b0;
    step(3);
    idle = 1'b1;
    step(1);
    if (mode == 1) rx_ready = 1'b1;
    if (mode == 2) ovr_clr = 1'b1;
    step(1);
    rx_ready = 1'b0;
    ovr_clr = 1'b0;
    step(2);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("rst_valid", rx_valid, 0);
    chk("rst_dat", rx_dat, 0);
    chk("rst_bits", bits, 11);
    chk("rst_baud", baud, 49);
    chk("rst_flags", {perr, ferr, brk, ovr}, 0);
    rst_n = 1'b1;
    step(2);

    send_frame(12'b10100001010, 11, 0);
    chk("f1_dat", rx_dat, 8'h85);
    chk("f1_valid", rx_valid, 1);
    chk("f1_flags", {perr, ferr, brk}, 3'b000);
    accept();

    send_frame(12'b11100001010, 11, 0);
    chk("par_dat", rx_dat, 8'h85);
    chk("par_perr", perr, 1);
    accept();

    send_frame(12'b00100001010, 11, 0);
    chk("stop_ferr", ferr, 1);
    accept();

    send_frame(12'b0, 11, 0);
    chk("brk_dat", rx_dat, 8'h00);
    chk("brk_flags", {brk, ferr}, 2'b11);
    accept();

    send_frame(12'b10100001010, 11, 0);
    send_frame(12'b11100001010, 11, 0);
    chk("ovr_dat", rx_dat, 8'h85);
    chk("ovr_perr", perr, 0);
    chk("ovr_set", ovr, 1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr_clr", ovr, 0);

    // accept coinciding with EVAL loads the new frame, no overrun
    send_frame(12'b00100001010, 11, 1);
    chk("coin_ferr", ferr, 1);
    chk("coin_ovr", ovr, 0);
    chk("coin_valid", rx_valid, 1);

    // overrun set and clear in the same cycle: set wins
    send_frame(12'b10100001010, 11, 2);
    chk("setclr_ovr", ovr, 1);
    chk("setclr_ferr", ferr, 1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    accept();

    rx_en = 1'b0;
    send_frame(12'b10100001010, 11, 0);
    chk("dis_valid", rx_valid, 0);
    rx_en = 1'b1;
    step(1);

    // config writes during BUSY stay pending; the last one wins
    sr = 64'(12'b10100001010) << 53;
    idle = 1'b0;
    step(2);
    cfg_we = 1'b1; cfg_dw = 2'b00; cfg_par = 2'b00; cfg_stop = 1'b0; cfg_baud = 64'd7;
    step(1);
    cfg_dw = 2'b10; cfg_par = 2'b01; cfg_stop = 1'b1; cfg_baud = 64'd10;
    step(1);
    cfg_we = 1'b0;
    chk("pend_bits", bits, 11);
    chk("pend_baud", baud, 49);
    idle = 1'b1;
    step(4);
    chk("pend_dat", rx_dat, 8'h85);
    chk("new_baud", baud, 10);
    chk("new_bits", bits, 11);
    accept();

    send_frame(12'b11010000010, 11, 0);
    chk("e72_dat", rx_dat, 8'h41);
    chk("e72_flags", {perr, ferr}, 2'b00);
    accept();

    cfg_we = 1'b1; cfg_dw = 2'b00; cfg_par = 2'b00; cfg_stop = 1'b0; cfg_baud = 64'd3;
    step(1);
    cfg_we = 1'b0;
    chk("n51_bits", bits, 7);
    send_frame(12'd106, 7, 0);
    chk("n51_dat", rx_dat, 8'h15);
    chk("n51_flags", {perr, ferr}, 2'b00);
    send_frame(12'd106, 7, 0);
    chk("n51_ovr", ovr, 1);

    // async reset in the middle of a frame
    sr = 64'(12'b10100001010) << 53;
    idle = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ovr", ovr, 0);
    chk("mrst_bits", bits, 11);
    chk("mrst_baud", baud, 49);
    chk("mrst_dat", rx_dat, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_valid", rx_valid, 0);
    idle = 1'b1;
    step(4);
    chk("stale_valid", rx_valid, 1);
    chk("stale_dat", rx_dat, 8'h85);
    accept();
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
